// File: rtl/usb_tx_pkg.sv
// ---------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB transmit path.
//   tx_stuff_state_t : state encoding of the bit-stuffer/serializer FSM
//   DATA_W_DEF       : default byte width shifted per load
//   STUFF_RUN_DEF    : default run of consecutive 1s that forces an inserted 0
//   J_IDLE_BIT       : level driven toward the NRZI encoder when the line idles
// ---------------------------------------------------------------------------
package usb_tx_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int STUFF_RUN_DEF = 6;

    localparam logic J_IDLE_BIT = 1'b1;

    // IDLE  : nothing to send, waiting for the hold register to fill
    // LOAD  : single cycle moving the held byte into the shift register
    // SEND  : shifting data bits, one per bit strobe
    // STUFF : emitting an inserted 0 after a full run of 1s
    // DONE  : last bit has been held a full bit time, return the line to J
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        STUFF,
        DONE
    } tx_stuff_state_t;

endpackage : usb_tx_pkg

// File: rtl/tx_byte_hold_reg.sv
// ---------------------------------------------------------------------------
// tx_byte_hold_reg
// One-entry valid/ready holding register with a "last byte" flag. Decouples
// the packet builder from the serializer so the next byte can be waiting by
// the time the current byte has been shifted out.
// Ports:
//   clk_i, rst_i    : clock and asynchronous active-high reset
//   data_i, last_i  : incoming byte and its end-of-packet qualifier
//   valid_i         : incoming byte valid
//   ready_o         : register empty, a byte is accepted when valid_i&&ready_o
//   pop_i           : consumer takes the held byte this cycle
//   full_o          : a byte is held
//   data_o, last_o  : held byte and its end-of-packet qualifier
// ---------------------------------------------------------------------------
module tx_byte_hold_reg
    import usb_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              pop_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              push;

    // Ready comes straight from the full flop, so it is glitch-free and
    // never depends on the consumer in the same cycle. Because a push needs
    // the register empty and a pop needs it full, the two can never collide.
    assign ready_o = !full_q;
    assign push    = valid_i && ready_o;

    // Capture a new byte on a successful handshake; release the entry when
    // the consumer pops it. Contents are left alone otherwise.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        if (push) begin
            full_d = 1'b1;
            data_d = data_i;
            last_d = last_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    // Storage flops for the single entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign last_o = last_q;

endmodule : tx_byte_hold_reg

// File: rtl/tx_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tx_bit_stuffer
// USB transmit bit stuffer / serializer. Takes packet bytes (SYNC first)
// over a valid/ready handshake, shifts them out LSB first at one bit per
// bit strobe, and inserts a 0 after every STUFF_RUN consecutive 1s. Sits
// between the packet builder and the NRZI encoder.
// Ports:
//   clk_i            : system clock, rising edge
//   rst_i            : asynchronous active-high reset
//   bit_strobe_i     : one-cycle pulse per USB bit time
//   tx_byte_i        : next packet byte
//   tx_byte_valid_i  : tx_byte_i / tx_last_i valid
//   tx_last_i        : tx_byte_i is the final byte of the packet
//   tx_byte_ready_o  : hold register empty
//   stuffed_bit_o    : serial bit toward the NRZI encoder
//   tx_active_o      : stuffed_bit_o carries packet bits
//   is_stuff_o       : stuffed_bit_o is an inserted 0
//   pkt_done_o       : one-cycle pulse, packet fully shifted
//   underrun_o       : one-cycle pulse, next byte missing, packet aborted
// ---------------------------------------------------------------------------
module tx_bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int STUFF_RUN = STUFF_RUN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_strobe_i,
    input  logic [DATA_W-1:0] tx_byte_i,
    input  logic              tx_byte_valid_i,
    input  logic              tx_last_i,
    output logic              tx_byte_ready_o,
    output logic              stuffed_bit_o,
    output logic              tx_active_o,
    output logic              is_stuff_o,
    output logic              pkt_done_o,
    output logic              underrun_o
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int OW = $clog2(STUFF_RUN + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
    localparam logic [OW-1:0] ONES_LIM = OW'(STUFF_RUN - 1);

    tx_stuff_state_t   state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              last_q, last_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [OW-1:0]     ones_cnt_q, ones_cnt_d;
    logic              stuffed_bit_q, stuffed_bit_d;
    logic              tx_active_q, tx_active_d;
    logic              is_stuff_q, is_stuff_d;
    logic              pkt_done_q, pkt_done_d;
    logic              underrun_q, underrun_d;

    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    logic              hold_pop;

    logic              late_fetch;
    logic [DATA_W-1:0] send_word;
    logic              send_last;
    logic [CW-1:0]     send_cnt;
    logic              send_bit;
    logic              resolve_end;

    tx_byte_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (tx_byte_i),
        .last_i  (tx_last_i),
        .valid_i (tx_byte_valid_i),
        .ready_o (tx_byte_ready_o),
        .pop_i   (hold_pop),
        .full_o  (hold_full),
        .data_o  (hold_data),
        .last_o  (hold_last)
    );

    // A byte that finished with nothing waiting parks SEND with bit_cnt at
    // DATA_W. If a byte arrives before the next strobe it is shifted out
    // directly from the hold register; otherwise that strobe is the underrun.
    // This mux picks the word the SEND state is working on.
    always_comb begin
        late_fetch = (bit_cnt_q == CNT_FULL);
        send_word  = late_fetch ? hold_data : shift_q;
        send_last  = late_fetch ? hold_last : last_q;
        send_cnt   = late_fetch ? '0 : bit_cnt_q;
        send_bit   = send_word[0];
    end

    // Next-state and output logic. Everything except IDLE->LOAD and the LOAD
    // step itself only moves on a bit strobe, so the registered outputs
    // change exactly one cycle after a strobe. A stuff decision wins over a
    // byte end; the byte end is then resolved after the stuff bit goes out.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        last_d        = last_q;
        bit_cnt_d     = bit_cnt_q;
        ones_cnt_d    = ones_cnt_q;
        stuffed_bit_d = stuffed_bit_q;
        tx_active_d   = tx_active_q;
        is_stuff_d    = is_stuff_q;
        pkt_done_d    = 1'b0;
        underrun_d    = 1'b0;
        hold_pop      = 1'b0;
        resolve_end   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hold_full) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                hold_pop   = 1'b1;
                shift_d    = hold_data;
                last_d     = hold_last;
                bit_cnt_d  = '0;
                ones_cnt_d = '0;
                state_d    = SEND;
            end

            SEND: begin
                if (bit_strobe_i) begin
                    if (late_fetch && !hold_full) begin
                        underrun_d    = 1'b1;
                        tx_active_d   = 1'b0;
                        is_stuff_d    = 1'b0;
                        stuffed_bit_d = J_IDLE_BIT;
                        shift_d       = '0;
                        bit_cnt_d     = '0;
                        ones_cnt_d    = '0;
                        state_d       = IDLE;
                    end else begin
                        hold_pop      = late_fetch;
                        last_d        = send_last;
                        stuffed_bit_d = send_bit;
                        tx_active_d   = 1'b1;
                        is_stuff_d    = 1'b0;
                        shift_d       = send_word >> 1;
                        bit_cnt_d     = send_cnt + 1'b1;
                        ones_cnt_d    = send_bit ? ones_cnt_q + 1'b1 : '0;
                        if (send_bit && (ones_cnt_q == ONES_LIM)) begin
                            state_d = STUFF;
                        end else if (send_cnt == LAST_IDX) begin
                            resolve_end = 1'b1;
                        end
                    end
                end
            end

            STUFF: begin
                if (bit_strobe_i) begin
                    stuffed_bit_d = 1'b0;
                    is_stuff_d    = 1'b1;
                    ones_cnt_d    = '0;
                    if (bit_cnt_q == CNT_FULL) begin
                        resolve_end = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            DONE: begin
                if (bit_strobe_i) begin
                    tx_active_d   = 1'b0;
                    is_stuff_d    = 1'b0;
                    stuffed_bit_d = J_IDLE_BIT;
                    pkt_done_d    = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Byte boundary: finish the packet, chain straight into the held byte
        // with no gap bit (the 1s run carries across), or park waiting for
        // one more strobe's worth of time before declaring an underrun.
        if (resolve_end) begin
            if (last_d) begin
                state_d = DONE;
            end else if (hold_full && !hold_pop) begin
                hold_pop  = 1'b1;
                shift_d   = hold_data;
                last_d    = hold_last;
                bit_cnt_d = '0;
                state_d   = SEND;
            end else begin
                bit_cnt_d = CNT_FULL;
                state_d   = SEND;
            end
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            last_q        <= 1'b0;
            bit_cnt_q     <= '0;
            ones_cnt_q    <= '0;
            stuffed_bit_q <= 1'b0;
            tx_active_q   <= 1'b0;
            is_stuff_q    <= 1'b0;
            pkt_done_q    <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            last_q        <= last_d;
            bit_cnt_q     <= bit_cnt_d;
            ones_cnt_q    <= ones_cnt_d;
            stuffed_bit_q <= stuffed_bit_d;
            tx_active_q   <= tx_active_d;
            is_stuff_q    <= is_stuff_d;
            pkt_done_q    <= pkt_done_d;
            underrun_q    <= underrun_d;
        end
    end

    assign stuffed_bit_o = stuffed_bit_q;
    assign tx_active_o   = tx_active_q;
    assign is_stuff_o    = is_stuff_q;
    assign pkt_done_o    = pkt_done_q;
    assign underrun_o    = underrun_q;

endmodule : tx_bit_stuffer

// File: tb/tb_tx_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tb_tx_bit_stuffer
// Self-checking bench for tx_bit_stuffer. Each scenario task loads packet
// bytes into pktBuf, pushes the expected serial stream (from an independent
// run-length model) into a scoreboard queue, feeds the bytes, and waits for
// the monitor to drain the queue. The monitor pops one expectation for every
// strobe that produces output.
// ---------------------------------------------------------------------------
module tb_tx_bit_stuffer;

    localparam logic [1:0] KIND_BIT   = 2'd0;
    localparam logic [1:0] KIND_DONE  = 2'd1;
    localparam logic [1:0] KIND_UNDER = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       bitVal;
        logic       stuff;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       bitStrobe;
    logic [7:0] txByte;
    logic       txByteValid;
    logic       txLast;
    logic       txByteReady;
    logic       stuffedBit;
    logic       txActive;
    logic       isStuff;
    logic       pktDone;
    logic       underrun;

    exp_t       sbQueue[$];
    logic [7:0] pktBuf[8];

    int assertCount = 0;
    int failCount   = 0;
    int strobePeriod = 4;
    int strobePhase  = 0;
    bit monEn        = 1'b0;
    bit strobePrev   = 1'b0;
    bit sawReadyLow  = 1'b0;
    bit feedTimeout  = 1'b0;
    int dataSeen   = 0;
    int stuffSeen  = 0;
    int doneSeen   = 0;
    int underSeen  = 0;
    int eventsSeen = 0;

    exp_t       expItem;
    logic [1:0] gotKind;

    tx_bit_stuffer #(
        .DATA_W    (8),
        .STUFF_RUN (6)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bit_strobe_i    (bitStrobe),
        .tx_byte_i       (txByte),
        .tx_byte_valid_i (txByteValid),
        .tx_last_i       (txLast),
        .tx_byte_ready_o (txByteReady),
        .stuffed_bit_o   (stuffedBit),
        .tx_active_o     (txActive),
        .is_stuff_o      (isStuff),
        .pkt_done_o      (pktDone),
        .underrun_o      (underrun)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bit strobe: one-cycle pulse every strobePeriod clocks, changed just
    // after the rising edge so the DUT always samples a settled value.
    initial begin
        bitStrobe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (strobePhase >= strobePeriod - 1) begin
                bitStrobe   = 1'b1;
                strobePhase = 0;
            end else begin
                bitStrobe = 1'b0;
                strobePhase++;
            end
        end
    end

    // Scoreboard monitor. Sampled on the falling edge: if a strobe was seen
    // by the DUT on the previous rising edge, any output event is popped and
    // compared. Between strobes the pulse outputs must be low.
    always @(negedge clk) begin
        if (monEn && strobePrev) begin
            if (pktDone || underrun || txActive) begin
                gotKind = pktDone ? KIND_DONE : (underrun ? KIND_UNDER : KIND_BIT);
                eventsSeen++;
                if (gotKind == KIND_DONE) doneSeen++;
                if (gotKind == KIND_UNDER) underSeen++;
                if (gotKind == KIND_BIT && isStuff) stuffSeen++;
                if (gotKind == KIND_BIT && !isStuff) dataSeen++;
                assertCount++;
                if (sbQueue.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL sb_extra_event: got kind=%0d bit=%b stuff=%b, required no event", gotKind, stuffedBit, isStuff);
                end else begin
                    expItem = sbQueue.pop_front();
                    if ((gotKind !== expItem.kind) ||
                        ((gotKind == KIND_BIT) && ((stuffedBit !== expItem.bitVal) || (isStuff !== expItem.stuff))) ||
                        ((gotKind != KIND_BIT) && (txActive !== 1'b0 || isStuff !== 1'b0)) ||
                        ((gotKind == KIND_DONE) && (stuffedBit !== 1'b1))) begin
                        failCount++;
                        $display("[TB] FAIL sb_event: got kind=%0d bit=%b stuff=%b active=%b, required kind=%0d bit=%b stuff=%b",
                                 gotKind, stuffedBit, isStuff, txActive, expItem.kind, expItem.bitVal, expItem.stuff);
                    end
                end
            end
        end else if (monEn) begin
            assertCount++;
            if (pktDone !== 1'b0 || underrun !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL pulse_off_strobe: got done=%b underrun=%b, required 0/0", pktDone, underrun);
            end
        end
        strobePrev = bitStrobe;
    end

    // Reference model: LSB-first bits, a 0 after every sixth consecutive 1,
    // the run carrying across bytes, then the packet-ending event.
    task automatic pushModel(input int n, input bit lastFlag, output int stuffs);
        int   ones;
        exp_t e;
        ones   = 0;
        stuffs = 0;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 8; i++) begin
                e.kind   = KIND_BIT;
                e.bitVal = pktBuf[b][i];
                e.stuff  = 1'b0;
                sbQueue.push_back(e);
                ones = pktBuf[b][i] ? ones + 1 : 0;
                if (ones == 6) begin
                    e.bitVal = 1'b0;
                    e.stuff  = 1'b1;
                    sbQueue.push_back(e);
                    ones = 0;
                    stuffs++;
                end
            end
        end
        e.kind   = lastFlag ? KIND_DONE : KIND_UNDER;
        e.bitVal = 1'b0;
        e.stuff  = 1'b0;
        sbQueue.push_back(e);
    endtask

    // Drive pktBuf[0..n-1] over the handshake, keeping valid high between
    // bytes; notes whether ready was ever seen low while valid was high.
    task automatic applyStimulus(input int n, input bit lastFlag);
        int waitCycles;
        for (int b = 0; b < n; b++) begin
            txByte      = pktBuf[b];
            txLast      = lastFlag && (b == n - 1);
            txByteValid = 1'b1;
            waitCycles  = 0;
            while (txByteReady !== 1'b1 && waitCycles < 2000) begin
                sawReadyLow = 1'b1;
                @(posedge clk);
                #1;
                waitCycles++;
            end
            if (waitCycles >= 2000) feedTimeout = 1'b1;
            @(posedge clk);
            #1;
        end
        txByteValid = 1'b0;
        txLast      = 1'b0;
    endtask

    // Wait for the scoreboard to empty, then allow a few idle bit times so
    // any spurious trailing event is caught.
    task automatic waitDrain(input int maxCycles, output bit drained);
        int cyc;
        cyc = 0;
        while (sbQueue.size() != 0 && cyc < maxCycles) begin
            @(posedge clk);
            cyc++;
        end
        drained = (sbQueue.size() == 0);
        repeat (3 * strobePeriod + 2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        txByte      = 8'h00;
        txByteValid = 1'b0;
        txLast      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        assertCount++;
        if (txByteReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_ready: got %b, required 1", txByteReady);
        end
        assertCount++;
        if ({stuffedBit, txActive, isStuff, pktDone, underrun} !== 5'b0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %b, required 00000", {stuffedBit, txActive, isStuff, pktDone, underrun});
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        monEn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single_ff();
        int stuffs;
        int ev0;
        bit drained;
        strobePeriod = 1;
        ev0 = eventsSeen;
        pktBuf[0] = 8'hFF;
        pushModel(1, 1'b1, stuffs);
        applyStimulus(1, 1'b1);
        waitDrain(500, drained);
        assertCount++;
        if (!drained || feedTimeout) begin
            failCount++;
            $display("[TB] FAIL ff_drain: got %0d pending, required 0", sbQueue.size());
        end
        assertCount++;
        if (eventsSeen - ev0 !== 10) begin
            failCount++;
            $display("[TB] FAIL ff_strobe_count: got %0d, required 10", eventsSeen - ev0);
        end
        sbQueue.delete();
    endtask

    task automatic test_span();
        int stuffs;
        int st0;
        bit drained;
        strobePeriod = 3;
        st0 = stuffSeen;
        pktBuf[0] = 8'h80;
        pktBuf[1] = 8'h3F;
        pushModel(2, 1'b1, stuffs);
        applyStimulus(2, 1'b1);
        waitDrain(1000, drained);
        assertCount++;
        if (!drained || feedTimeout) begin
            failCount++;
            $display("[TB] FAIL span_drain: got %0d pending, required 0", sbQueue.size());
        end
        assertCount++;
        if (stuffSeen - st0 !== stuffs) begin
            failCount++;
            $display("[TB] FAIL span_stuff_count: got %0d, required %0d", stuffSeen - st0, stuffs);
        end
        sbQueue.delete();
    endtask

    task automatic test_byte_edge();
        int stuffs;
        int un0;
        bit drained;
        strobePeriod = 4;
        un0 = underSeen;
        pktBuf[0] = 8'h7F;
        pktBuf[1] = 8'h7F;
        pktBuf[2] = 8'hFC;
        pktBuf[3] = 8'h7F;
        pushModel(4, 1'b1, stuffs);
        applyStimulus(4, 1'b1);
        waitDrain(2000, drained);
        assertCount++;
        if (!drained || feedTimeout) begin
            failCount++;
            $display("[TB] FAIL edge_drain: got %0d pending, required 0", sbQueue.size());
        end
        assertCount++;
        if (underSeen - un0 !== 0) begin
            failCount++;
            $display("[TB] FAIL edge_no_underrun: got %0d, required 0", underSeen - un0);
        end
        sbQueue.delete();
    endtask

    task automatic test_underrun();
        int stuffs;
        int dn0;
        int un0;
        bit drained;
        strobePeriod = 4;
        dn0 = doneSeen;
        un0 = underSeen;
        pktBuf[0] = 8'h01;
        pushModel(1, 1'b0, stuffs);
        applyStimulus(1, 1'b0);
        waitDrain(1000, drained);
        assertCount++;
        if (!drained || feedTimeout) begin
            failCount++;
            $display("[TB] FAIL underrun_drain: got %0d pending, required 0", sbQueue.size());
        end
        assertCount++;
        if ((underSeen - un0 !== 1) || (doneSeen - dn0 !== 0)) begin
            failCount++;
            $display("[TB] FAIL underrun_events: got underrun=%0d done=%0d, required 1/0", underSeen - un0, doneSeen - dn0);
        end
        assertCount++;
        if (txActive !== 1'b0 || txByteReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL underrun_idle: got active=%b ready=%b, required 0/1", txActive, txByteReady);
        end
        sbQueue.delete();
    endtask

    task automatic test_mid_reset();
        int stuffs;
        int d0;
        int dn0;
        int cyc;
        bit drained;
        strobePeriod = 4;
        d0 = dataSeen;
        pktBuf[0] = 8'hAA;
        pushModel(1, 1'b1, stuffs);
        applyStimulus(1, 1'b1);
        cyc = 0;
        while (dataSeen < d0 + 4 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        assertCount++;
        if (dataSeen < d0 + 4) begin
            failCount++;
            $display("[TB] FAIL midrst_bits: got %0d bits, required 4", dataSeen - d0);
        end
        monEn = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        assertCount++;
        if ({txByteReady, stuffedBit, txActive, isStuff, pktDone, underrun} !== 6'b100000) begin
            failCount++;
            $display("[TB] FAIL midrst_outputs: got %b, required 100000",
                     {txByteReady, stuffedBit, txActive, isStuff, pktDone, underrun});
        end
        sbQueue.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        monEn = 1'b1;
        dn0 = doneSeen;
        pktBuf[0] = 8'h00;
        pushModel(1, 1'b1, stuffs);
        applyStimulus(1, 1'b1);
        waitDrain(1000, drained);
        assertCount++;
        if (!drained || feedTimeout || (doneSeen - dn0 !== 1)) begin
            failCount++;
            $display("[TB] FAIL midrst_new_pkt: got %0d pending, %0d done, required 0/1", sbQueue.size(), doneSeen - dn0);
        end
        sbQueue.delete();
    endtask

    task automatic test_back_to_back();
        int stuffs;
        int d0;
        int st0;
        bit drained;
        strobePeriod = 4;
        d0 = dataSeen;
        st0 = stuffSeen;
        sawReadyLow = 1'b0;
        pktBuf[0] = 8'hA5;
        pktBuf[1] = 8'hFF;
        pktBuf[2] = 8'h3C;
        pushModel(3, 1'b1, stuffs);
        applyStimulus(3, 1'b1);
        waitDrain(2000, drained);
        assertCount++;
        if (!drained || feedTimeout) begin
            failCount++;
            $display("[TB] FAIL b2b_drain: got %0d pending, required 0", sbQueue.size());
        end
        assertCount++;
        if (sawReadyLow !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_ready_low: got %b, required 1", sawReadyLow);
        end
        assertCount++;
        if ((dataSeen - d0 !== 24) || (stuffSeen - st0 !== stuffs)) begin
            failCount++;
            $display("[TB] FAIL b2b_bit_counts: got data=%0d stuff=%0d, required 24/%0d", dataSeen - d0, stuffSeen - st0, stuffs);
        end
        sbQueue.delete();
    endtask

    // Scenario sequence and summary.
    initial begin
        rst = 1'b1;
        test_reset();
        test_single_ff();
        test_span();
        test_byte_edge();
        test_underrun();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_tx_bit_stuffer
